// File: rtl/shift_unit_if.sv
// Request/result bundle for shift_unit: one request channel in, one result channel out.
// Both channels use valid/ready: a transfer happens on a rising edge where valid & ready.
interface shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: one bit per clock (SLL/SRL/SRA/ROL), result held until consumed.
// Handshake: in_valid/in_ready accept in IDLE only; out_valid/out_ready release in DONE only.
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_unit_if.slave  bus,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [1:0]         mode_q, mode_d;
  logic               carry_q, carry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= MODE_SLL;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    count_d      = count_q;
    mode_d       = mode_q;
    carry_d      = carry_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          mode_d  = bus.in_mode;
          count_d = bus.in_shamt;
          carry_d = 1'b0;
          state_d = (bus.in_shamt != '0) ? S_SHIFT : S_DONE;
        end
      end

      S_SHIFT: begin
        case (mode_q)
          MODE_SLL: begin
            data_d  = {data_q[WIDTH-2:0], 1'b0};
            carry_d = data_q[WIDTH-1];
          end
          MODE_SRL: begin
            data_d  = {1'b0, data_q[WIDTH-1:1]};
            carry_d = data_q[0];
          end
          MODE_SRA: begin
            data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            carry_d = data_q[0];
          end
          default: begin
            data_d  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            carry_d = data_q[WIDTH-1];
          end
        endcase
        count_d = count_q - SHAMT_W'(1);
        // The step that consumes the last remaining count ends the operation.
        if (count_q == SHAMT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;
  assign bus.out_zero  = (data_q == '0);
  assign busy          = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit at WIDTH=8: each task drives one scenario and checks inline.
module tb_shift_unit;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int lat;

  shift_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request from a negedge, accept on the next posedge, then measure
  // latency as the number of posedges from the accept edge until out_valid is seen.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                      input logic hold_valid);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0; bus.in_mode = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b0) $display("FAIL reset_out_carry got=%b exp=0", bus.out_carry); else pass_cnt++;
    total_cnt++; if (bus.out_zero !== 1'b1) $display("FAIL reset_out_zero got=%b exp=1", bus.out_zero); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_sll();
    bus.out_ready = 1'b1;
    send(8'h81, 3'd1, 2'b00, 1'b0);
    total_cnt++; if (lat !== 2) $display("FAIL sll_latency got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h02) $display("FAIL sll_data got=%h exp=02", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b1) $display("FAIL sll_carry got=%b exp=1", bus.out_carry); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL sll_in_ready_after got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL sll_out_valid_after got=%b exp=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_sra();
    send(8'h80, 3'd3, 2'b10, 1'b0);
    total_cnt++; if (lat !== 4) $display("FAIL sra_latency got=%0d exp=4", lat); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'hF0) $display("FAIL sra_data got=%h exp=f0", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b0) $display("FAIL sra_carry got=%b exp=0", bus.out_carry); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL sra_busy_done got=%b exp=1", busy); else pass_cnt++;
    consume();
  endtask

  task automatic test_rol_srl();
    send(8'hA5, 3'd4, 2'b11, 1'b0);
    total_cnt++; if (lat !== 5) $display("FAIL rol_latency got=%0d exp=5", lat); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h5A) $display("FAIL rol_data got=%h exp=5a", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b0) $display("FAIL rol_carry got=%b exp=0", bus.out_carry); else pass_cnt++;
    consume();
    send(8'h01, 3'd1, 2'b01, 1'b0);
    total_cnt++; if (bus.out_data !== 8'h00) $display("FAIL srl_data got=%h exp=00", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b1) $display("FAIL srl_carry got=%b exp=1", bus.out_carry); else pass_cnt++;
    total_cnt++; if (bus.out_zero !== 1'b1) $display("FAIL srl_zero got=%b exp=1", bus.out_zero); else pass_cnt++;
    consume();
  endtask

  task automatic test_shamt_zero();
    send(8'h3C, 3'd0, 2'b00, 1'b0);
    total_cnt++; if (lat !== 1) $display("FAIL zero_shamt_latency got=%0d exp=1", lat); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h3C) $display("FAIL zero_shamt_data got=%h exp=3c", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b0) $display("FAIL zero_shamt_carry got=%b exp=0", bus.out_carry); else pass_cnt++;
    total_cnt++; if (bus.out_zero !== 1'b0) $display("FAIL zero_shamt_zflag got=%b exp=0", bus.out_zero); else pass_cnt++;
    consume();
  endtask

  // SRL 0xF0 by 2 -> 0x3C, carry 0; then hold out_ready low while in_valid stays high.
  task automatic test_stall();
    send(8'hF0, 3'd2, 2'b01, 1'b1);
    bus.in_data = 8'h11; bus.in_shamt = 3'd0; bus.in_mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.out_data !== 8'h3C) $display("FAIL stall_data[%0d] got=%h exp=3c", i, bus.out_data); else pass_cnt++;
      total_cnt++; if (bus.out_carry !== 1'b0) $display("FAIL stall_carry[%0d] got=%b exp=0", i, bus.out_carry); else pass_cnt++;
      total_cnt++; if (bus.out_zero !== 1'b0) $display("FAIL stall_zero[%0d] got=%b exp=0", i, bus.out_zero); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, bus.in_ready); else pass_cnt++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    consume();
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL stall_release_state got=%0d exp=0", dbg_state); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL stall_release_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h3C) $display("FAIL stall_no_second_accept got=%h exp=3c", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_shamt = 3'd7; bus.in_mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL midshift_busy got=%b exp=1", busy); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL midshift_rst_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL midshift_rst_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h00) $display("FAIL midshift_rst_data got=%h exp=00", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b0) $display("FAIL midshift_rst_carry got=%b exp=0", bus.out_carry); else pass_cnt++;
    total_cnt++; if (bus.out_zero !== 1'b1) $display("FAIL midshift_rst_zero got=%b exp=1", bus.out_zero); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midshift_rst_busy got=%b exp=0", busy); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL midshift_no_result got=%b exp=0", bus.out_valid); else pass_cnt++;
    send(8'hFF, 3'd7, 2'b00, 1'b0);
    total_cnt++; if (lat !== 8) $display("FAIL after_rst_latency got=%0d exp=8", lat); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'h80) $display("FAIL after_rst_data got=%h exp=80", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_carry !== 1'b1) $display("FAIL after_rst_carry got=%b exp=1", bus.out_carry); else pass_cnt++;
    consume();
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra();
    test_rol_srl();
    test_shamt_zero();
    test_stall();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width in bits; legal values are powers of two, minimum 2.
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(WIDTH), meaning the shift-amount width.
REQ-003 clk  input  1  The block SHALL use this single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  The block SHALL use this reset, asynchronous and active-low.
REQ-005 in_valid  input  1  Request present.
REQ-006 in_ready  output  1  Block can accept a request.
REQ-007 in_data  input  WIDTH  Operand.
REQ-008 in_shamt  input  SHAMT_W  Shift amount, range 0..WIDTH-1.
REQ-009 in_mode  input  2  Operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 out_valid  output  1  Result present.
REQ-011 out_ready  input  1  Consumer accepts the result.
REQ-012 out_data  output  WIDTH  Shifted result.
REQ-013 out_carry  output  1  Last bit shifted or rotated out.
REQ-014 out_zero  output  1  High when out_data == 0.
REQ-015 busy  output  1  High in SHIFT or DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 When in_valid & in_ready is seen at edge T, the block SHALL capture data, shamt and mode into internal registers, load count = shamt, and clear the carry register.
  - If shamt != 0, the FSM SHALL go to SHIFT.
  - If shamt == 0, the FSM SHALL go to DONE.
REQ-019 In SHIFT, each cycle SHALL perform a 1-bit step per the captured mode and decrement count:
  - SLL: left shift, zero fill, carry = old MSB.
  - SRL: right shift, zero fill, carry = old LSB.
  - SRA: right shift, MSB replicated, carry = old LSB.
  - ROL: rotate left by one, carry = old MSB.
REQ-020 The step that brings count to 0 SHALL transition the FSM to DONE.
REQ-021 Latency SHALL be shamt+1 cycles from the accept edge to out_valid high, with a minimum of 1 cycle for shamt == 0.
REQ-022 For shamt == 0, out_data SHALL equal in_data and out_carry SHALL be 0.
REQ-023 In DONE, out_data, out_carry and out_zero SHALL hold stable until out_valid & out_ready; on that edge the FSM SHALL return to IDLE.
REQ-024 A new request SHALL be accepted no earlier than the cycle after the result handshake; there is no same-cycle handoff.
REQ-025 in_valid while not in IDLE SHALL be ignored and SHALL NOT alter state; inputs are sampled only at accept.
REQ-026 out_zero SHALL be derived combinationally from the result register.

Reset
REQ-027 rst_n low SHALL immediately force the FSM to IDLE and clear count, the data register and the carry register, regardless of clk.
REQ-028 During and after reset, the outputs SHALL be: in_ready=1, out_valid=0, out_data=0, out_carry=0, out_zero=1, busy=0.
REQ-029 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation with no result presented.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover: SLL 0x81 by 1, out_ready=1 -> out_valid at T+2, out_data 0x02, out_carry 1, then in_ready 1.
REQ-032 The bench SHALL cover: SRA 0x80 by 3 -> out_data 0xF0, out_carry 0, out_valid at T+4.
REQ-033 The bench SHALL cover: ROL 0xA5 by 4 -> out_data 0x5A, out_carry 0; then SRL 0x01 by 1 -> out_data 0x00, out_carry 1, out_zero 1.
REQ-034 The bench SHALL cover: shamt 0, SLL 0x3C -> out_valid at T+1, out_data 0x3C, out_carry 0.
REQ-035 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready 0, no second accept; out_ready 1 -> IDLE next cycle.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-SHIFT (SLL 0xFF by 7, 3 cycles in) -> immediate IDLE with all outputs at reset values; a subsequent request completes correctly.
